minmax_tracker_8bit: RTL and testbench
======================================

Name: minmax_tracker_8bit

Overview:
- Sequential stage downstream of the 8-bit magnitude comparator. It consumes a stream of unsigned samples and tracks the running minimum, running maximum and sample count.
- Applies the comparator's GT/LT/EQ decision each cycle against the held extremes.
- Used by the Power_ALU datapath for window statistics (peak and floor detection) over a bounded burst terminated by in_last.

Parameters:
- WIDTH, 8, sample and extreme-register width (unsigned).
- CNT_W, 8, width of the sample counter (saturating).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a new burst; honoured only in IDLE or DONE.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  unsigned sample.
- in_last  input  1  qualifies the final sample of the burst; sampled only when in_valid && in_ready.
- in_ready  output  1  block accepts a sample this cycle.
- min_out  output  WIDTH  running/final minimum.
- max_out  output  WIDTH  running/final maximum.
- count  output  CNT_W  number of accepted samples, saturating.
- busy  output  1  high in FIRST or TRACK.
- done  output  1  high while in DONE; results frozen.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high; all state changes on the rising edge of clk.
- Reset values: state=IDLE, min_out=0, max_out=0, count=0, in_ready=0, busy=0, done=0.
- Handshake: a sample is accepted when in_valid && in_ready. in_ready is a registered-state decode (high in FIRST and TRACK only) and does not depend on in_valid.
- Latency: updated min_out/max_out/count are visible one cycle after acceptance.
- IDLE: in_ready=0. start -> FIRST; min_out, max_out and count are cleared to 0 on that edge.
- FIRST: in_ready=1.
  - Accept sets min_out=max_out=in_data and count=1.
  - in_last -> DONE, else -> TRACK.
  - No accept: stay in FIRST.
- TRACK: in_ready=1. On accept:
  - in_data < min_out (A_LT_B): min_out <= in_data.
  - in_data > max_out (A_GT_B): max_out <= in_data.
  - Equal to either extreme: no update; the first occurrence is kept.
  - count increments; it holds at 2^CNT_W-1 once reached (no wrap).
  - in_last -> DONE.
  - Gaps with in_valid=0 leave all state unchanged.
- DONE: in_ready=0, done=1, and all results hold. start -> FIRST with results cleared on the same edge; done drops the next cycle.
- start asserted in FIRST or TRACK is ignored.
- start and in_valid in the same cycle in IDLE/DONE: the sample is not accepted, because in_ready=0.
- Reset mid-burst: rst has priority over every other input. The block returns to IDLE with reset values on the next edge; the partial burst is discarded.
- All comparisons are unsigned WIDTH-bit. No X-propagation from in_data when in_valid=0.

Optional Feature:
- Macro MINMAX_INDEX_EN.
- When defined:
  - Adds outputs min_idx [CNT_W-1:0] and max_idx [CNT_W-1:0], both reset to 0 and cleared on start.
  - Each holds the zero-based acceptance index of the sample that last updated the corresponding extreme. The first sample gives index 0.
  - Ties keep the earlier index.
  - The index uses the pre-increment count value and saturates together with count.
- When undefined: the ports and their registers are absent and all other behaviour is identical.

Test Plan:
- Reset, then start, then accept 30,0,30,10,16,16,18 back-to-back with in_last on 18 -> min_out=0, max_out=30, count=7, done=1 one cycle after the last accept, in_ready=0. With MINMAX_INDEX_EN: min_idx=1, max_idx=0.
- Single sample 8'h12 with in_last on the first beat -> FIRST->DONE directly; min_out=max_out=8'h12, count=1.
- Samples 5,200,5 with in_valid low for 3 cycles between beats -> results are unchanged during the gaps; final min_out=5, max_out=200, count=3. start pulsed mid-burst has no effect.
- rst asserted after the 2nd of 4 samples -> next cycle state=IDLE, all outputs 0. in_valid held high afterwards is not accepted (in_ready=0).
- CNT_W=4: feed 20 samples without in_last, then one with in_last -> count holds at 15 and min_out/max_out remain correct.
- In DONE, assert start together with in_valid=1 and in_data=99 -> the sample is not accepted; next cycle FIRST with results 0; the subsequent beat in_data=7 with in_last gives min_out=max_out=7.

Source files
------------

// File: rtl/minmax_tracker_8bit.sv
// minmax_tracker_8bit
// Tracks the running minimum, running maximum and saturating sample count
// over a burst of unsigned samples delimited by start and in_last.
// Optional feature (macro MINMAX_INDEX_EN): adds min_idx/max_idx outputs
// holding the zero-based acceptance index of the sample that set each extreme.

module minmax_tracker_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
`ifdef MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_TRACK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

    // Unsigned magnitude compare of a against b: returns {a_gt_b, a_lt_b}.
    function automatic logic [1:0] mag_cmp(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [1:0] r;
        r[1] = (a > b);
        r[0] = (a < b);
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] min_r;
    logic [WIDTH-1:0] max_r;
    logic [CNT_W-1:0] count_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx_r;
    logic [CNT_W-1:0] max_idx_r;
`endif

    logic             accept_s;
    logic             lt_min_s;
    logic             gt_max_s;
    logic [1:0]       cmp_min_s;
    logic [1:0]       cmp_max_s;

    // Handshake and comparator decisions against the held extremes; in_data is
    // only considered when a sample is actually accepted.
    always_comb begin
        accept_s  = in_valid && ready_r;
        cmp_min_s = mag_cmp(in_data, min_r);
        cmp_max_s = mag_cmp(in_data, max_r);
        if (accept_s) begin
            lt_min_s = cmp_min_s[0];
            gt_max_s = cmp_max_s[1];
        end else begin
            lt_min_s = 1'b0;
            gt_max_s = 1'b0;
        end
    end

    // Burst FSM with the result registers and registered status decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            min_r     <= DAT_ZERO;
            max_r     <= DAT_ZERO;
            count_r   <= CNT_ZERO;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef MINMAX_INDEX_EN
            min_idx_r <= CNT_ZERO;
            max_idx_r <= CNT_ZERO;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r   <= ST_FIRST;
                        min_r     <= DAT_ZERO;
                        max_r     <= DAT_ZERO;
                        count_r   <= CNT_ZERO;
                        ready_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
`ifdef MINMAX_INDEX_EN
                        min_idx_r <= CNT_ZERO;
                        max_idx_r <= CNT_ZERO;
`endif
                    end
                end
                ST_FIRST: begin
                    if (accept_s) begin
                        min_r     <= in_data;
                        max_r     <= in_data;
                        count_r   <= CNT_ONE;
`ifdef MINMAX_INDEX_EN
                        min_idx_r <= CNT_ZERO;
                        max_idx_r <= CNT_ZERO;
`endif
                        if (in_last) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_TRACK;
                        end
                    end
                end
                ST_TRACK: begin
                    if (accept_s) begin
                        // Ties with an extreme leave it (and its index) alone.
                        if (lt_min_s) begin
                            min_r     <= in_data;
`ifdef MINMAX_INDEX_EN
                            min_idx_r <= count_r;
`endif
                        end
                        if (gt_max_s) begin
                            max_r     <= in_data;
`ifdef MINMAX_INDEX_EN
                            max_idx_r <= count_r;
`endif
                        end
                        if (count_r != CNT_MAX) begin
                            count_r <= count_r + CNT_ONE;
                        end
                        if (in_last) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready_r;
    assign min_out  = min_r;
    assign max_out  = max_r;
    assign count    = count_r;
    assign busy     = busy_r;
    assign done     = done_r;
`ifdef MINMAX_INDEX_EN
    assign min_idx  = min_idx_r;
    assign max_idx  = max_idx_r;
`endif

endmodule

// File: tb/tb_minmax_tracker_8bit.sv
// Scoreboard bench for minmax_tracker_8bit: the driver applies one input vector
// per cycle and pushes the reference model's expected outputs; the monitor pops
// one expectation per clock and compares it with what the DUT presents.
`timescale 1ns/1ps

module tb_minmax_tracker_8bit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_last;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, busy, done;
    logic [WIDTH-1:0] min_out, max_out;
    logic [CNT_W-1:0] count;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0] min_idx, max_idx;
`endif

    minmax_tracker_8bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .min_out(min_out), .max_out(max_out), .count(count),
        .busy(busy), .done(done)
`ifdef MINMAX_INDEX_EN
        , .min_idx(min_idx), .max_idx(max_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             rdy;
        logic             bsy;
        logic             dn;
        logic [WIDTH-1:0] mn;
        logic [WIDTH-1:0] mx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] mi;
        logic [CNT_W-1:0] xi;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase 0=idle 1=first 2=track 3=done; burst holds every
    // accepted sample of the current burst.
    int   phase = 0;
    int   burst[$];

    function automatic obs_t snapshot();
        obs_t o;
        int   mn, mx, mi, xi, n;
        n  = burst.size();
        mn = 0; mx = 0; mi = 0; xi = 0;
        if (n > 0) begin
            mn = burst[0]; mx = burst[0];
            for (int i = 1; i < n; i++) begin
                if (burst[i] < mn) begin mn = burst[i]; mi = i; end
                if (burst[i] > mx) begin mx = burst[i]; xi = i; end
            end
        end
        o.rdy = (phase == 1 || phase == 2);
        o.bsy = o.rdy;
        o.dn  = (phase == 3);
        o.mn  = WIDTH'(mn);
        o.mx  = WIDTH'(mx);
        o.cnt = CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
`ifdef MINMAX_INDEX_EN
        o.mi  = CNT_W'((mi > CNT_MAX) ? CNT_MAX : mi);
        o.xi  = CNT_W'((xi > CNT_MAX) ? CNT_MAX : xi);
`else
        o.mi  = '0;
        o.xi  = '0;
`endif
        return o;
    endfunction

    task automatic model_apply(input logic r, input logic s, input logic v,
                               input int d, input logic l);
        if (r) begin
            phase = 0;
            burst.delete();
        end else if (phase == 0 || phase == 3) begin
            if (s) begin
                phase = 1;
                burst.delete();
            end
        end else if (v) begin
            burst.push_back(d);
            phase = l ? 3 : 2;
        end
    endtask

    // One cycle of stimulus plus the matching expectation.
    task automatic step(input logic r, input logic s, input logic v,
                        input int d, input logic l);
        @(negedge clk);
        rst      = r;
        start    = s;
        in_valid = v;
        in_data  = WIDTH'(d);
        in_last  = l;
        model_apply(r, s, v, d, l);
        exp_q.push_back(snapshot());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 255), 1'b0);
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    always @(posedge clk) begin
        obs_t a, e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.rdy = in_ready; a.bsy = busy; a.dn = done;
            a.mn = min_out; a.mx = max_out; a.cnt = count;
`ifdef MINMAX_INDEX_EN
            a.mi = min_idx; a.xi = max_idx;
`else
            a.mi = '0; a.xi = '0;
`endif
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got rdy=%0b busy=%0b done=%0b min=%0d max=%0d cnt=%0d midx=%0d xidx=%0d want rdy=%0b busy=%0b done=%0b min=%0d max=%0d cnt=%0d midx=%0d xidx=%0d",
                         $time, a.rdy, a.bsy, a.dn, a.mn, a.mx, a.cnt, a.mi, a.xi,
                         e.rdy, e.bsy, e.dn, e.mn, e.mx, e.cnt, e.mi, e.xi);
            end
        end
    end

    int seq1[7] = '{30, 0, 30, 10, 16, 16, 18};
    int seq3[3] = '{5, 200, 5};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(2);

        // Back-to-back burst with repeated values and ties.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, seq1[i], (i == 6));
        idle(3);

        // Single-sample burst straight from FIRST to DONE.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h12, 1'b1);
        idle(2);

        // Gaps between beats, start pulsed mid-burst.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, seq3[i], (i == 2));
            if (i < 2) begin
                step(1'b0, 1'b0, 1'b0, 77, 1'b0);
                step(1'b0, (i == 0), 1'b0, 250, 1'b1);
                step(1'b0, 1'b0, 1'b0, 1, 1'b0);
            end
        end
        idle(2);

        // Reset after the second of four samples, in_valid kept high after.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 40, 1'b0);
        step(1'b0, 1'b0, 1'b1, 60, 1'b0);
        step(1'b1, 1'b0, 1'b1, 80, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 90 + i, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Count saturation, extremes and indices set past the saturation point.
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            int d;
            d = $urandom_range(10, 250);
            if (i == 280) d = 1;
            if (i == 285) d = 255;
            step(1'b0, 1'b0, 1'b1, d, (i == 299));
        end
        idle(2);

        // start with in_valid in DONE: sample is not accepted.
        step(1'b0, 1'b1, 1'b1, 99, 1'b0);
        step(1'b0, 1'b0, 1'b1, 7, 1'b1);
        idle(2);

        // Randomized traffic including occasional start and reset.
        for (int i = 0; i < 3000; i++) begin
            logic r, s, v, l;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 11) == 0);
            step(r, s, v, $urandom_range(0, 255), l);
        end

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
